// File: rtl/mcdt_arbiter.sv
// Round-robin arbiter between three channel FIFOs and the shared MCDT output port.
// Define MCDT_ARB_BURST_EN to let a channel hold priority for up to BURST_LEN beats.
module mcdt_arbiter #(
    parameter int DW        = 32,
    parameter int BURST_LEN = 4
) (
    input  logic          clk_i,
    input  logic          rstn_i,
    input  logic [DW-1:0] ch0_data_i,
    input  logic          ch0_valid_i,
    input  logic          ch0_en_i,
    output logic          ch0_pop_o,
    input  logic [DW-1:0] ch1_data_i,
    input  logic          ch1_valid_i,
    input  logic          ch1_en_i,
    output logic          ch1_pop_o,
    input  logic [DW-1:0] ch2_data_i,
    input  logic          ch2_valid_i,
    input  logic          ch2_en_i,
    output logic          ch2_pop_o,
    output logic [DW-1:0] mcdt_data_o,
    output logic          mcdt_val_o,
    output logic [1:0]    mcdt_id_o,
    output logic [2:0]    mcdt_grant_o
);

    if (BURST_LEN < 1 || BURST_LEN > 15) begin : g_burst_len_check
        $error("mcdt_arbiter: BURST_LEN must be in 1..15");
    end

    logic [2:0]    req;
    logic          any;
    logic [1:0]    last;
    logic [1:0]    nxt1;
    logic [1:0]    nxt2;
    logic [1:0]    win;
    logic          hold;
    logic [2:0]    pop;
    logic [DW-1:0] win_data;

    assign req  = {ch2_valid_i & ch2_en_i, ch1_valid_i & ch1_en_i, ch0_valid_i & ch0_en_i};
    assign any  = |req;
    assign nxt1 = (last == 2'd2) ? 2'd0 : last + 2'd1;
    assign nxt2 = (nxt1 == 2'd2) ? 2'd0 : nxt1 + 2'd1;

`ifdef MCDT_ARB_BURST_EN
    typedef enum logic {IDLE, GRANT} state_t;

    localparam logic [3:0] BURST_MAX = 4'(BURST_LEN);

    state_t     state;
    logic [3:0] burst_cnt;

    // The last winner keeps priority only inside an unbroken run of grants.
    assign hold = (state == GRANT) && req[last] && (burst_cnt < BURST_MAX);

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            state     <= IDLE;
            burst_cnt <= 4'd0;
        end else if (any) begin
            state     <= GRANT;
            burst_cnt <= (state == GRANT && win == last && burst_cnt < BURST_MAX)
                         ? burst_cnt + 4'd1 : 4'd1;
        end else begin
            state     <= IDLE;
            burst_cnt <= 4'd0;
        end
    end
`else
    assign hold = 1'b0;
`endif

    // Search order last+1, last+2, last; falling through to last also covers "no request".
    always_comb begin
        win = last;
        if (hold)
            win = last;
        else if (req[nxt1])
            win = nxt1;
        else if (req[nxt2])
            win = nxt2;
    end

    always_comb begin
        case (win)
            2'd1:    win_data = ch1_data_i;
            2'd2:    win_data = ch2_data_i;
            default: win_data = ch0_data_i;
        endcase
    end

    assign pop          = (rstn_i && any) ? (3'b001 << win) : 3'b000;
    assign ch0_pop_o    = pop[0];
    assign ch1_pop_o    = pop[1];
    assign ch2_pop_o    = pop[2];
    assign mcdt_grant_o = pop;

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            mcdt_val_o  <= 1'b0;
            mcdt_data_o <= '0;
            mcdt_id_o   <= 2'd0;
            last        <= 2'd2;
        end else if (any) begin
            mcdt_val_o  <= 1'b1;
            mcdt_data_o <= win_data;
            mcdt_id_o   <= win;
            last        <= win;
        end else begin
            mcdt_val_o  <= 1'b0;
            mcdt_data_o <= '0;
        end
    end

endmodule

// File: tb/tb_mcdt_arbiter.sv
// Self-checking bench for mcdt_arbiter: directed scenarios plus randomized traffic
// compared against a queue-based behavioural model of the arbitration rules.
module tb_mcdt_arbiter;
    localparam int DW = 32;
    localparam int BL = 4;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic [DW-1:0] d0, d1, d2;
    logic [2:0]    v, en, gate;
    logic [2:0]    pop_o, grant;
    logic [DW-1:0] mdata;
    logic          mval;
    logic [1:0]    mid;

    logic [DW-1:0] q0[$], q1[$], q2[$];
    int            nerr = 0, nchecks = 0;
    int            m_last = 2, m_run = 0;
    bit            m_busy = 1'b0;
    logic          exp_val = 1'b0;
    logic [1:0]    exp_id = 2'd0;
    logic [DW-1:0] exp_data = '0;
    int            ids[$];
    int            ch1_pops = 0;
    int            want[12];

    always #5 clk = ~clk;

    mcdt_arbiter #(.DW(DW), .BURST_LEN(BL)) dut (
        .clk_i(clk), .rstn_i(rstn),
        .ch0_data_i(d0), .ch0_valid_i(v[0]), .ch0_en_i(en[0]), .ch0_pop_o(pop_o[0]),
        .ch1_data_i(d1), .ch1_valid_i(v[1]), .ch1_en_i(en[1]), .ch1_pop_o(pop_o[1]),
        .ch2_data_i(d2), .ch2_valid_i(v[2]), .ch2_en_i(en[2]), .ch2_pop_o(pop_o[2]),
        .mcdt_data_o(mdata), .mcdt_val_o(mval), .mcdt_id_o(mid), .mcdt_grant_o(grant)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nchecks++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] qfront(input int c);
        case (c)
            0:       return q0[0];
            1:       return q1[0];
            default: return q2[0];
        endcase
    endfunction

    task automatic qpop(input int c);
        case (c)
            0:       void'(q0.pop_front());
            1:       void'(q1.pop_front());
            default: void'(q2.pop_front());
        endcase
    endtask

    task automatic fill(input int c, input int n, input logic [DW-1:0] base);
        for (int i = 0; i < n; i++) begin
            case (c)
                0:       q0.push_back(base + DW'(i));
                1:       q1.push_back(base + DW'(i));
                default: q2.push_back(base + DW'(i));
            endcase
        end
    endtask

    // Arbitration rule: optional burst hold, then first requester of last+1, last+2, last.
    function automatic int model_win(input logic [2:0] req);
`ifdef MCDT_ARB_BURST_EN
        if (m_busy && req[m_last] && m_run < BL) return m_last;
`endif
        for (int k = 1; k <= 3; k++) begin
            if (req[(m_last + k) % 3]) return (m_last + k) % 3;
        end
        return -1;
    endfunction

    task automatic cycle();
        logic [2:0] req, ep;
        int w;
        @(negedge clk);
        v[0] = (q0.size() > 0) && gate[0];
        v[1] = (q1.size() > 0) && gate[1];
        v[2] = (q2.size() > 0) && gate[2];
        d0 = (q0.size() > 0) ? q0[0] : '0;
        d1 = (q1.size() > 0) ? q1[0] : '0;
        d2 = (q2.size() > 0) ? q2[0] : '0;
        #1;
        req = v & en;
        w = rstn ? model_win(req) : -1;
        ep = (w >= 0) ? (3'b001 << w) : 3'b000;
        check("pop", pop_o, ep);
        check("grant", grant, ep);
        if (pop_o[1]) ch1_pops++;
        @(posedge clk);
        #1;
        if (!rstn) begin
            exp_val = 1'b0; exp_data = '0; exp_id = 2'd0;
            m_last = 2; m_busy = 1'b0; m_run = 0;
        end else if (w >= 0) begin
            exp_data = qfront(w);
            qpop(w);
            exp_val = 1'b1;
            exp_id = 2'(w);
            m_run = (m_busy && w == m_last && m_run < BL) ? m_run + 1 : 1;
            m_last = w;
            m_busy = 1'b1;
        end else begin
            exp_val = 1'b0; exp_data = '0; m_busy = 1'b0; m_run = 0;
        end
        check("val", mval, exp_val);
        check("id", mid, exp_id);
        check("data", mdata, exp_data);
        if (mval) ids.push_back(int'(mid));
    endtask

    task automatic run(input int n);
        repeat (n) cycle();
    endtask

    task automatic expect_ids(input string tag, input int n);
        check({tag, "_count"}, ids.size(), n);
        for (int i = 0; i < n && i < ids.size(); i++) check(tag, ids[i], want[i]);
    endtask

    task automatic refill_all();
        q0.delete(); q1.delete(); q2.delete();
        fill(0, 24, 32'hA000_0000);
        fill(1, 24, 32'hA100_0000);
        fill(2, 24, 32'hA200_0000);
    endtask

    initial begin
        en = 3'b111; gate = 3'b111; v = 3'b000;
        d0 = '0; d1 = '0; d2 = '0;

        // Reset held with every channel requesting: no pops, outputs cleared.
        refill_all();
        rstn = 1'b0;
        run(10);
        rstn = 1'b1;

        // Channel 0 alone streams back-to-back.
        q0.delete(); q1.delete(); q2.delete();
        fill(0, 10, 32'h00C0_0000);
        ids.delete();
        run(12);
        want = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        expect_ids("ch0_only", 10);

        // All three requesting after a fresh reset.
        rstn = 1'b0; run(1); rstn = 1'b1;
        refill_all();
        ids.delete();
`ifdef MCDT_ARB_BURST_EN
        run(12);
        want = '{0, 0, 0, 0, 1, 1, 1, 1, 2, 2, 2, 2};
        expect_ids("burst_rr", 12);
        run(2);
        gate[0] = 1'b0;
        run(1);
        check("burst_drop", (ids.size() > 0) ? ids[$] : -1, 1);
        gate[0] = 1'b1;
`else
        run(6);
        want = '{0, 1, 2, 0, 1, 2, 0, 0, 0, 0, 0, 0};
        expect_ids("rr3", 6);
`endif

        // Channel 1 disabled while valid: never popped.
        rstn = 1'b0; run(1); rstn = 1'b1;
        refill_all();
        en = 3'b101;
        ch1_pops = 0;
        ids.delete();
        run(4);
`ifdef MCDT_ARB_BURST_EN
        want = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
`else
        want = '{0, 2, 0, 2, 0, 0, 0, 0, 0, 0, 0, 0};
`endif
        expect_ids("ch1_off", 4);
        check("ch1_pops", ch1_pops, 0);
        en = 3'b111;

        // Reset pulsed mid-stream, then first grant must go back to channel 0.
        refill_all();
        run(5);
        rstn = 1'b0;
        run(1);
        check("rst_val", mval, 1'b0);
        check("rst_pop", pop_o, 3'b000);
        rstn = 1'b1;
        ids.delete();
        run(1);
        check("rst_first", (ids.size() > 0) ? ids[0] : -1, 0);

        // Randomized traffic with gating, enable changes and occasional reset.
        for (int i = 0; i < 500; i++) begin
            gate = 3'($urandom);
            en = ($urandom_range(0, 3) == 0) ? 3'($urandom) : 3'b111;
            rstn = ($urandom_range(0, 49) != 0);
            if (q0.size() < 3) q0.push_back($urandom);
            if (q1.size() < 3) q1.push_back($urandom);
            if (q2.size() < 3) q2.push_back($urandom);
            cycle();
        end

        $display("Result: errors=%0d of %0d checks", nerr, nchecks);
        $finish;
    end
endmodule
